// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Owns the single register file write port (wa/wd/we) and shares
//            it between two write requesters with round-robin arbitration and
//            a valid/ready handshake. After reset, or on clr, it sweeps zero
//            into every register address before accepting requests.
// Ports    :
//   clk, rst             clock (posedge), asynchronous active-high reset
//   req0_valid/addr/data requester 0 write request
//   req0_ready           requester 0 accepted this cycle
//   req1_valid/addr/data requester 1 write request
//   req1_ready           requester 1 accepted this cycle
//   clr                  start a new zeroing sweep
//   busy                 sweep in progress
//   init_done            one-cycle pulse after the last sweep write
//   wa, wd, we           register file write port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int          DATA_W       = 4,
  parameter int          ADDR_W       = 3,
  parameter int unsigned ZERO_PROTECT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr,
  output logic              busy,
  output logic              init_done,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_CNT_LAST = '1;
  localparam logic [ADDR_W-1:0] C_CNT_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              init_done_q, init_done_d;

  logic              grant_valid;
  logic              grant_sel;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  // Grant selection: a lone requester always wins; a contested cycle goes to
  // the requester named by ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (state_q == ST_RUN) begin
      grant_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
        grant_sel = ptr_q;
      end else begin
        grant_sel = req1_valid;
      end
    end
    grant_addr = grant_sel ? req1_addr : req0_addr;
    grant_data = grant_sel ? req1_data : req0_data;
  end

  // Write port and handshake outputs. rst gates them combinationally so the
  // port goes quiet the moment reset is asserted, not at the next edge.
  always_comb begin
    we         = 1'b0;
    wa         = '0;
    wd         = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          we = 1'b1;
          wa = cnt_q;
        end
        ST_RUN: begin
          busy = 1'b0;
          if (grant_valid) begin
            req0_ready = ~grant_sel;
            req1_ready = grant_sel;
            wa         = grant_addr;
            wd         = grant_data;
            // Protected address 0 still handshakes, but the write is dropped.
            we         = !((ZERO_PROTECT != 0) && (grant_addr == '0));
          end
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
  end

  assign init_done = init_done_q;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    init_done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      ST_RUN: begin
        // Every grant completes in its own cycle since ready follows valid.
        if (grant_valid) begin
          ptr_d = ~grant_sel;
        end
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
    end
  end

endmodule
`default_nettype wire
